// File: rtl/mem_ctrl_if.sv
// Bus bundle between the pipeline requesters, the memory controller and the
// byte-wide synchronous RAM.
//   mm_*  : MEM-stage load/store request and its completion (mm_ok, mm_n_o)
//   if_*  : IF-stage word fetch request and its completion (if_ok, if_n_o)
//   ram_* : byte RAM port; ram_din returns one cycle after ram_a
// modport slave  : the controller's view
// modport master : the view of the requesters plus the RAM
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mm_e;
    logic              mm_wr;
    logic [ADDR_W-1:0] mm_a;
    logic [31:0]       mm_n_i;
    logic [1:0]        mm_cu;
    logic              mm_ok;
    logic [31:0]       mm_n_o;
    logic              if_e;
    logic [ADDR_W-1:0] if_a;
    logic              if_ok;
    logic [31:0]       if_n_o;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport slave (
        input  mm_e, mm_wr, mm_a, mm_n_i, mm_cu, if_e, if_a, ram_din,
        output mm_ok, mm_n_o, if_ok, if_n_o, ram_dout, ram_a, ram_wr
    );

    modport master (
        output mm_e, mm_wr, mm_a, mm_n_i, mm_cu, if_e, if_a, ram_din,
        input  mm_ok, mm_n_o, if_ok, if_n_o, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serializes MEM-stage loads/stores and IF-stage fetches
// into little-endian byte beats on a byte-wide synchronous RAM and reassembles
// read bytes into a word. Each completed transfer gives its owner a one-cycle
// ok pulse.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_ctrl_if.slave: mm_* / if_* request side and ram_* RAM side
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = fetch, 0 = MEM stage
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       result_q, result_d;
    logic [2:0]        n_q, n_d;           // byte count, 1..4
    logic [2:0]        beat_q, beat_d;
    logic [31:0]       mm_n_q, mm_n_d;
    logic [31:0]       if_n_q, if_n_d;

    logic              in_beat;
    logic [2:0]        beat_m1;
    logic [31:0]       wr_shift;

    assign bus.mm_n_o = mm_n_q;
    assign bus.if_n_o = if_n_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        result_d = result_q;
        n_d      = n_q;
        beat_d   = beat_q;
        mm_n_d   = mm_n_q;
        if_n_d   = if_n_q;

        bus.mm_ok    = 1'b0;
        bus.if_ok    = 1'b0;
        bus.ram_wr   = 1'b0;
        bus.ram_dout = 8'd0;

        // Beats are the first N cycles in RD/WR; the extra read capture cycle
        // (beat_q == n_q) drives address 0.
        in_beat   = ((state_q == RD) || (state_q == WR)) && (beat_q < n_q);
        bus.ram_a = in_beat ? (addr_q + ADDR_W'(beat_q)) : '0;
        beat_m1   = beat_q - 3'd1;
        wr_shift  = data_q >> {beat_q, 3'b000};

        case (state_q)
            IDLE: begin
                beat_d   = 3'd0;
                result_d = 32'd0;
                if (bus.mm_e) begin
                    owner_d = 1'b0;
                    wr_d    = bus.mm_wr;
                    addr_d  = bus.mm_a;
                    data_d  = bus.mm_n_i;
                    n_d     = {1'b0, bus.mm_cu} + 3'd1;
                    state_d = bus.mm_wr ? WR : RD;
                end else if (bus.if_e) begin
                    owner_d = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = bus.if_a;
                    n_d     = 3'd4;
                    state_d = RD;
                end
            end
            RD: begin
                beat_d = beat_q + 3'd1;
                // RAM data lags the address by one cycle, so the byte for
                // beat k lands while beat_q == k+1.
                if (beat_q != 3'd0) begin
                    result_d = result_q | ({24'd0, bus.ram_din} << {beat_m1[1:0], 3'b000});
                end
                if (beat_q == n_q) begin
                    state_d = DONE;
                    if (owner_q) begin
                        if_n_d = result_d;
                    end else begin
                        mm_n_d = result_d;
                    end
                end
            end
            WR: begin
                bus.ram_wr   = 1'b1;
                bus.ram_dout = wr_shift[7:0];
                beat_d       = beat_q + 3'd1;
                if (beat_q == n_q - 3'd1) begin
                    state_d = DONE;
                    mm_n_d  = 32'd0;
                end
            end
            DONE: begin
                // Request inputs are deliberately not looked at here: the
                // requester drops e combinationally on ok.
                bus.mm_ok = ~owner_q;
                bus.if_ok = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mm_n_q  <= 32'd0;
            if_n_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            mm_n_q  <= mm_n_d;
            if_n_q  <= if_n_d;
        end
    end

    // Transfer context; only meaningful while state_q is not IDLE.
    always_ff @(posedge clk) begin
        owner_q  <= owner_d;
        wr_q     <= wr_d;
        addr_q   <= addr_d;
        data_q   <= data_d;
        result_q <= result_d;
        n_q      <= n_d;
        beat_q   <= beat_d;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model, directed and random requests, and a
// scoreboard of expected completions and RAM write beats derived from a
// shadow byte memory.
module tb_mem_ctrl;
    logic clk;
    logic rst;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          owner;   // 1 = fetch
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t sb[$];
    wr_t  wq[$];
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int vectors;
    int miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    // Expected outcome of an MEM-stage request, from the shadow memory.
    task automatic push_mm(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] cu);
        int n;
        logic [31:0] r;
        n = int'(cu) + 1;
        r = 32'd0;
        for (int k = 0; k < n; k++) begin
            if (wr) begin
                ref_mem[a + 32'(k)] = d[8*k +: 8];
                wq.push_back('{a + 32'(k), d[8*k +: 8]});
            end else begin
                r = r | (32'(ref_rd(a + 32'(k))) << (8*k));
            end
        end
        sb.push_back('{1'b0, wr ? 32'd0 : r});
    endtask

    task automatic push_if(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++) r = r | (32'(ref_rd(a + 32'(k))) << (8*k));
        sb.push_back('{1'b1, r});
    endtask

    task automatic mm_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] cu);
        int cnt;
        int lat;
        @(negedge clk);
        bus.mm_e = 1'b1; bus.mm_wr = wr; bus.mm_a = a; bus.mm_n_i = d; bus.mm_cu = cu;
        push_mm(wr, a, d, cu);
        lat = wr ? int'(cu) + 2 : int'(cu) + 3;
        @(posedge clk); #1;
        // Scramble the held inputs: the transfer must run on latched values.
        bus.mm_a = $urandom; bus.mm_n_i = $urandom;
        bus.mm_cu = 2'($urandom); bus.mm_wr = 1'($urandom);
        cnt = 0;
        while (!bus.mm_ok && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(wr ? "mm_store_latency" : "mm_load_latency", 32'(cnt + 1), 32'(lat));
        bus.mm_e = 1'b0;
        @(posedge clk);
    endtask

    task automatic if_req(input logic [31:0] a);
        int cnt;
        @(negedge clk);
        bus.if_e = 1'b1; bus.if_a = a;
        push_if(a);
        @(posedge clk); #1;
        bus.if_a = $urandom;
        cnt = 0;
        while (!bus.if_ok && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("if_latency", 32'(cnt + 1), 32'd6);
        bus.if_e = 1'b0;
        @(posedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mm_ok"},    32'(bus.mm_ok),    32'd0);
        chk({tag, "_if_ok"},    32'(bus.if_ok),    32'd0);
        chk({tag, "_mm_n_o"},   bus.mm_n_o,        32'd0);
        chk({tag, "_if_n_o"},   bus.if_n_o,        32'd0);
        chk({tag, "_ram_a"},    bus.ram_a,         32'd0);
        chk({tag, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
        chk({tag, "_ram_wr"},   32'(bus.ram_wr),   32'd0);
    endtask

    initial begin
        int cnt;
        logic [31:0] a;
        logic [31:0] d;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.mm_e = 1'b0; bus.mm_wr = 1'b0; bus.mm_a = '0; bus.mm_n_i = '0; bus.mm_cu = '0;
        bus.if_e = 1'b0; bus.if_a = '0;
        bus.ram_din = 8'd0;

        // Byte RAM: write on ram_wr, registered read of ram_a.
        fork
            forever begin
                @(posedge clk);
                if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
                bus.ram_din <= ram_rd(bus.ram_a);
            end
        join_none

        // Monitor: pops expectations whenever the controller completes or writes.
        fork
            forever begin
                exp_t e;
                wr_t  w;
                @(negedge clk);
                if (!rst) begin
                    if (bus.mm_ok || bus.if_ok) begin
                        chk("ok_onehot", 32'(bus.mm_ok & bus.if_ok), 32'd0);
                        chk("ok_expected", 32'(sb.size() > 0), 32'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("ok_owner", 32'(bus.if_ok), 32'(e.owner));
                            if (e.owner) chk("if_n_o", bus.if_n_o, e.data);
                            else         chk("mm_n_o", bus.mm_n_o, e.data);
                        end
                    end
                    if (bus.ram_wr) begin
                        chk("wr_expected", 32'(wq.size() > 0), 32'd1);
                        if (wq.size() > 0) begin
                            w = wq.pop_front();
                            chk("wr_addr", bus.ram_a, w.a);
                            chk("wr_data", 32'(bus.ram_dout), 32'(w.d));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Word load of known bytes, then byte/half stores read back.
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        mm_req(1'b0, 32'h100, 32'h0, 2'd3);
        mm_req(1'b1, 32'h200, 32'hDEADBEEF, 2'd0);
        mm_req(1'b1, 32'h202, 32'hDEADBEEF, 2'd1);
        mm_req(1'b0, 32'h200, 32'h0, 2'd3);
        mm_req(1'b0, 32'h201, 32'h0, 2'd2);
        mm_req(1'b0, 32'h203, 32'h0, 2'd0);

        // Simultaneous requests: MEM byte load first, fetch after one idle cycle.
        @(negedge clk);
        a = 32'h100 + 32'($urandom_range(0, 3));
        bus.mm_e = 1'b1; bus.mm_wr = 1'b0; bus.mm_a = a; bus.mm_cu = 2'd0;
        bus.if_e = 1'b1; bus.if_a = 32'h0;
        push_mm(1'b0, a, 32'h0, 2'd0);
        push_if(32'h0);
        @(posedge clk); #1;
        cnt = 0;
        while (!bus.mm_ok && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("arb_mm_latency", 32'(cnt + 1), 32'd3);
        bus.mm_e = 1'b0;
        cnt = 0;
        while (!bus.if_ok && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("arb_if_after_mm", 32'(cnt), 32'd7);
        bus.if_e = 1'b0;
        @(posedge clk);

        // Address wrap-around on a fetch and on a store/load.
        if_req(32'hFFFFFFFE);
        mm_req(1'b1, 32'hFFFFFFFF, 32'hA1B2C3D4, 2'd3);
        mm_req(1'b0, 32'hFFFFFFFE, 32'h0, 2'd3);

        // Reset during beat 2 of a word store: beats 0..2 reach the RAM, nothing after.
        @(negedge clk);
        d = $urandom;
        bus.mm_e = 1'b1; bus.mm_wr = 1'b1; bus.mm_a = 32'h3000; bus.mm_n_i = d; bus.mm_cu = 2'd3;
        for (int k = 0; k < 3; k++) wq.push_back('{32'h3000 + 32'(k), d[8*k +: 8]});
        @(posedge clk); #1;
        bus.mm_a = $urandom; bus.mm_n_i = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        bus.mm_e = 1'b0;
        @(posedge clk); #1;
        chk_outputs_zero("midreset");
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        mm_req(1'b1, 32'h400, 32'h0BADF00D, 2'd3);
        mm_req(1'b0, 32'h400, 32'h0, 2'd3);

        // Random traffic over a small window so stores and loads overlap.
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 4));
            if (($urandom_range(0, 7)) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else                             a = 32'h1000 + 32'($urandom_range(0, 31));
            if (op == 4) if_req(a);
            else mm_req(op < 2, a, $urandom, 2'($urandom));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
